// File: rtl/and_bist_pkg.sv
// Shared types and the reference reduction function for the lane self-test.
package and_bist_pkg;

  typedef enum logic [1:0] {
    MODE_AND  = 2'd0,
    MODE_NAND = 2'd1,
    MODE_OR   = 2'd2,
    MODE_NOR  = 2'd3
  } mode_e;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_APPLY  = 3'd1,
    S_SETTLE = 3'd2,
    S_CHECK  = 3'd3,
    S_DONE   = 3'd4
  } state_e;

  // Reference result for one vector. Callers pass the AND and OR reductions of
  // the vector, so the function does not depend on the lane width.
  function automatic logic golden(mode_e mode, logic all_set, logic any_set);
    logic r;
    case (mode)
      MODE_AND:  r = all_set;
      MODE_NAND: r = ~all_set;
      MODE_OR:   r = any_set;
      default:   r = ~any_set;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/and_bist_lane.sv
// One gate lane: registered input vector, mode-selectable reduction, stuck-at-0 mux.
module and_bist_lane #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             load,
  input  logic [WIDTH-1:0] vec,
  input  logic [1:0]       mode,
  input  logic             stuck,
  output logic             y
);

  logic [WIDTH-1:0] in_q;
  logic             red;

  // Capture the applied vector; frozen while ena is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           in_q <= '0;
    else if (ena && load) in_q <= vec;
  end

  // Gate under test: mode[1] picks OR vs AND, mode[0] inverts; stuck forces 0.
  always_comb begin
    red = mode[1] ? (|in_q) : (&in_q);
    red = red ^ mode[0];
    y   = stuck ? 1'b0 : red;
  end

endmodule

// File: rtl/and_reduce_bist.sv
// Lane array plus exhaustive self-test engine: sweeps every vector, compares each
// lane with the reference, counts mismatches and captures the first failure.
module and_reduce_bist
  import and_bist_pkg::*;
#(
  parameter int WIDTH    = 6,
  parameter int CHANNELS = 12,
  parameter int SETTLE   = 2,
  parameter int CNT_W    = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        ena,
  input  logic                        start,
  input  logic [1:0]                  mode,
  input  logic                        fault_en,
  input  logic [$clog2(CHANNELS)-1:0] fault_ch,
  output logic                        busy,
  output logic                        done,
  output logic                        pass,
  output logic [CNT_W-1:0]            err_cnt,
  output logic [$clog2(CHANNELS)-1:0] first_fail_ch,
  output logic [WIDTH-1:0]            first_fail_vec
);

  localparam int CH_W = $clog2(CHANNELS);
  localparam int SC_W = $clog2(SETTLE + 1);
  localparam int PC_W = $clog2(CHANNELS + 1);
  localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;
  localparam logic [WIDTH-1:0] VEC_LAST = '1;
  localparam logic [SC_W-1:0]  SC_LAST  = SC_W'(SETTLE - 1);

  state_e            state, state_next;
  logic [WIDTH-1:0]  vec;
  logic [SC_W-1:0]   settle_cnt;
  mode_e             mode_q;
  logic              fault_en_q;
  logic [CH_W-1:0]   fault_ch_q;

  logic [CHANNELS-1:0] lane_y, stuck, mism;
  logic                gold;
  logic [PC_W-1:0]     pc;
  logic [CH_W-1:0]     low_idx;
  logic [CNT_W-1:0]    err_next;
  int unsigned         sum;

  // Lane array: all lanes load the current vector while the engine is in APPLY.
  for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
    assign stuck[i] = fault_en_q && (fault_ch_q == CH_W'(i));
    and_bist_lane #(.WIDTH(WIDTH)) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .ena   (ena),
      .load  (state == S_APPLY),
      .vec   (vec),
      .mode  (mode_q),
      .stuck (stuck[i]),
      .y     (lane_y[i])
    );
  end

  // Compare, popcount, saturating add and lowest failing lane.
  always_comb begin
    gold    = golden(mode_q, &vec, |vec);
    mism    = lane_y ^ {CHANNELS{gold}};
    pc      = '0;
    low_idx = '0;
    for (int i = 0; i < CHANNELS; i++) pc = pc + PC_W'(mism[i]);
    for (int i = CHANNELS - 1; i >= 0; i--) if (mism[i]) low_idx = CH_W'(i);
    sum      = 32'(err_cnt) + 32'(pc);
    err_next = (sum > CNT_MAX) ? '1 : CNT_W'(sum);
  end

  // State register; ena low freezes the sequence.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   state <= S_IDLE;
    else if (ena) state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (start) state_next = S_APPLY;
      S_APPLY:  state_next = S_SETTLE;
      S_SETTLE: if (settle_cnt == SC_LAST) state_next = S_CHECK;
      S_CHECK:  state_next = (vec == VEC_LAST) ? S_DONE : S_APPLY;
      S_DONE:   state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // Datapath: run config latch, counters, result capture. done is cleared on
  // every enabled edge except the DONE one, so a stall stretches the pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec            <= '0;
      settle_cnt     <= '0;
      mode_q         <= MODE_AND;
      fault_en_q     <= 1'b0;
      fault_ch_q     <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_cnt        <= '0;
      first_fail_ch  <= '0;
      first_fail_vec <= '0;
    end else if (ena) begin
      done <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          mode_q         <= mode_e'(mode);
          fault_en_q     <= fault_en;
          fault_ch_q     <= fault_ch;
          err_cnt        <= '0;
          pass           <= 1'b0;
          first_fail_ch  <= '0;
          first_fail_vec <= '0;
          busy           <= 1'b1;
          vec            <= '0;
        end
        S_APPLY:  settle_cnt <= '0;
        S_SETTLE: settle_cnt <= settle_cnt + 1'b1;
        S_CHECK: begin
          err_cnt <= err_next;
          // err_cnt never returns to zero within a run, so zero means no
          // earlier failing check.
          if (err_cnt == '0 && |mism) begin
            first_fail_ch  <= low_idx;
            first_fail_vec <= vec;
          end
          if (vec != VEC_LAST) vec <= vec + 1'b1;
        end
        S_DONE: begin
          done <= 1'b1;
          busy <= 1'b0;
          pass <= (err_cnt == '0);
        end
        default: ;
      endcase
    end
  end

endmodule
